// File: rtl/wlmont_pkg.sv
// Shared definitions for the word-level Montgomery blocks: the R exponent and
// the conversion FSM states.
package wlmont_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // K = W * ceil(LOGQ / W); reduction stages must use this same function.
    function automatic int calc_K(input int logq, input int w);
        return w * ((logq + w - 1) / w);
    endfunction

endpackage

// File: rtl/wlmont_to_domain_dbl_step.sv
// Combinational modular doubling: y = (2a) mod q, for a < q.
module wlmont_dbl_step #(
    parameter int LOGQ = 31
) (
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] q,
    output logic [LOGQ-1:0] y
);

    logic [LOGQ:0]   s;
    logic [LOGQ+1:0] d;

    assign s = {a, 1'b0};
    assign d = {1'b0, s} - {2'b00, q};
    // Sign bit of d selects the unreduced double.
    assign y = LOGQ'(d[LOGQ+1] ? {1'b0, s} : d);

endmodule

// File: rtl/wlmont_to_domain.sv
// Bit-serial conversion into the word-level Montgomery domain:
// y = x * 2^K mod q using K modular doublings, valid/ready on both sides.
module wlmont_to_domain
    import wlmont_pkg::*;
#(
    parameter int LOGQ = 31,
    parameter int W    = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [LOGQ-1:0] q,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] x_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] y_o
);

    localparam int K  = calc_K(LOGQ, W);
    localparam int CW = $clog2(K) + 1;

    state_t          state, state_nxt;
    logic [LOGQ-1:0] q_r, acc, acc_dbl;
    logic [CW-1:0]   cnt;
    logic            in_hs, out_hs;

    // in_ready is gated in the handshake so nothing is taken while it is still low after reset.
    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;
    assign y_o    = acc;

    wlmont_dbl_step #(.LOGQ(LOGQ)) u_dbl (
        .a (acc),
        .q (q_r),
        .y (acc_dbl)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_hs) state_nxt = RUN;
            RUN:     if (cnt == CW'(K - 1)) state_nxt = DONE;
            DONE:    if (out_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            q_r       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            case (state)
                IDLE: if (in_hs) begin
                    q_r <= q;
                    acc <= x_i;
                    cnt <= '0;
                end
                RUN: begin
                    acc <= acc_dbl;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wlmont_to_domain.sv
// Directed and random checks of wlmont_to_domain at LOGQ=31/W=16 and LOGQ=5/W=4.
module tb_wlmont_to_domain;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] q_b, x_b;
    logic [1:0]  iv, ordy, ir, ov;
    logic [30:0] y0;
    logic [4:0]  y1;
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    wlmont_to_domain #(.LOGQ(31), .W(16)) u_dut0 (
        .clk(clk), .rstn(rstn), .q(q_b[30:0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .x_i(x_b[30:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y_o(y0)
    );

    wlmont_to_domain #(.LOGQ(5), .W(4)) u_dut1 (
        .clk(clk), .rstn(rstn), .q(q_b[4:0]), .in_valid(iv[1]), .in_ready(ir[1]),
        .x_i(x_b[4:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .y_o(y1)
    );

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned gold(input longint unsigned qv, input longint unsigned xv,
                                             input int k);
        return (xv << k) % qv;
    endfunction

    function automatic longint unsigned yv(input int sel);
        return (sel != 0) ? longint'(y1) : longint'(y0);
    endfunction

    // One conversion; lat counts edges from the accept edge to out_valid.
    task automatic conv(input int sel, input longint unsigned qv, input longint unsigned xv,
                        input bit take, input bit scr,
                        output longint unsigned y, output int lat);
        int t;
        @(negedge clk);
        q_b = 32'(qv);
        x_b = 32'(xv);
        iv[sel] = 1'b1;
        t = 0;
        while (!ir[sel] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ir[sel]) chk("accept_timeout", longint'(ir[sel]), 1);
        @(posedge clk);
        @(negedge clk);
        iv[sel] = 1'b0;
        lat = 0;
        while (!ov[sel] && lat < 100) begin
            if (scr) begin
                q_b = $urandom;
                x_b = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        if (!ov[sel]) chk("done_timeout", longint'(ov[sel]), 1);
        y = yv(sel);
        if (take) begin
            ordy[sel] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ordy[sel] = 1'b0;
        end
    endtask

    initial begin
        longint unsigned y, xr, exp;
        int lat;
        iv = '0; ordy = '0; q_b = '0; x_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(ir), 0);
        chk("rst_out_valid", longint'(ov), 0);
        chk("rst_y0", longint'(y0), 0);
        chk("rst_y1", longint'(y1), 0);
        rstn = 1'b1;

        conv(0, 64'h7FFF_FFFF, 1, 1, 0, y, lat);
        chk("q31_x1", y, 2);
        chk("q31_lat", longint'(lat), 32);
        conv(0, 64'h7FFF_FFFF, 64'd2147483646, 1, 0, y, lat);
        chk("q31_xqm1", y, 64'd2147483645);
        conv(0, 64'h7FFF_FFFF, 0, 1, 0, y, lat);
        chk("q31_x0", y, 0);

        conv(1, 13, 1, 1, 0, y, lat);
        chk("q13_x1", y, 9);
        chk("q13_lat", longint'(lat), 8);
        conv(1, 13, 12, 1, 0, y, lat);
        chk("q13_x12", y, 4);

        for (int i = 0; i < 1000; i++) begin
            xr = longint'($urandom_range(12, 0));
            conv(1, 13, xr, 1, 0, y, lat);
            chk("q13_rand", y, gold(13, xr, 8));
        end

        // Operand buses scrambled every RUN cycle.
        conv(0, 1000003, 123456, 1, 1, y, lat);
        chk("scramble", y, gold(1000003, 123456, 32));

        // Backpressure in DONE.
        conv(1, 13, 5, 0, 0, y, lat);
        chk("bp_y", y, 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", longint'(ov[1]), 1);
            chk("bp_hold", longint'(y1), 6);
            chk("bp_in_ready", longint'(ir[1]), 0);
        end
        ordy[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[1] = 1'b0;
        chk("bp_release_ready", longint'(ir[1]), 1);
        chk("bp_release_valid", longint'(ov[1]), 0);

        // Reset during RUN.
        q_b = 13; x_b = 7; iv[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_run_acc", longint'(y1 != 0), 1);
        #1 rstn = 1'b0;
        #1;
        chk("abort_valid", longint'(ov[1]), 0);
        chk("abort_y", longint'(y1), 0);
        chk("abort_ready", longint'(ir[1]), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", longint'(ir[1]), 1);
        conv(1, 13, 3, 1, 0, y, lat);
        exp = gold(13, 3, 8);
        chk("post_rst_conv", y, exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
